// File: rtl/delay_timer_sched.sv
// Shared programmable delay counter with a round-robin arbiter in front of it.
// One requester at a time owns the counter and gets a done pulse on expiry.
module delay_timer_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 11,
    parameter int MAXN  = 1250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt,
    output logic                  err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] MAXV = CBITS'(MAXN);
    localparam logic [NREQ-1:0]  ONE  = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CBITS-1:0] len_q, len_d;
    logic [CBITS-1:0] cnt_q, cnt_d;

    logic [CBITS-1:0] dly_a [NREQ];
    logic             pick_vld;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;
    logic [CBITS-1:0] pick_len;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_dly
        assign dly_a[g] = dly[g*CBITS +: CBITS];
    end

    // Walk from the farthest position back to the nearest so the
    // nearest pending requester after last_q is the one that sticks.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = wrap(int'(last_q) + off);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    assign pick_len = (dly_a[pick] > MAXV) ? MAXV : dly_a[pick];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick;
                    last_d  = pick;
                    len_d   = pick_len;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!req[idx_q]) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == len_q) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign gnt  = busy ? (ONE << idx_q) : '0;
    assign done = (state_q == S_DONE) ? (ONE << idx_q) : '0;
    assign cnt  = cnt_q;

    assign err = ((state_q == S_RUN) && (cnt_q > len_q))
              || ((state_q != S_RUN) && (cnt_q != '0))
              || (len_q > MAXV)
              || ((gnt & (gnt - ONE)) != '0);

    a_no_err: assert property (@(posedge clk) disable iff (rst) ##1 !err);
    a_done_onehot: assert property (@(posedge clk) $onehot0(done));

endmodule

// File: tb/tb_delay_timer_sched.sv
// Random round-robin rounds against a timeline model; done pulses are
// scored by a monitor against a queue of expected (requester, edge) pairs.
module tb_delay_timer_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 11;
    localparam int MAXN  = 1250;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] dly = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [CBITS-1:0]      cnt;
    logic                  err;

    delay_timer_sched #(
        .NREQ (NREQ),
        .CBITS(CBITS),
        .MAXN (MAXN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .dly (dly),
        .gnt (gnt),
        .done(done),
        .busy(busy),
        .cnt (cnt),
        .err (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int edge_n;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   model_last = NREQ - 1;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int sat(input int d);
        return (d > MAXN) ? MAXN : d;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("err_low", err, 0);
            if (done != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("done_id", done, 1 << mon_e.id);
                    check("done_edge", cyc, mon_e.edge_n);
                end
            end
        end
    end

    // Requesters in mask raise together; a hold requester re-requests once
    // after its first done. Model: serve in rr order, back to back, with one
    // idle cycle between a done and the next grant.
    task automatic run_round(input logic [NREQ-1:0] mask, input int dv[NREQ],
                             input logic [NREQ-1:0] hold);
        int need[NREQ];
        int served[NREQ];
        int left[NREQ];
        int t, j, ln, mx, peak, budget, any;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            dly[i*CBITS +: CBITS] = CBITS'(dv[i]);
            need[i]   = hold[i] ? 2 : 1;
            left[i]   = mask[i] ? need[i] : 0;
            served[i] = 0;
        end
        t  = cyc + 1;
        mx = 0;
        any = 1;
        while (any != 0) begin
            j = -1;
            for (int off = 1; off <= NREQ; off++) begin
                if (j < 0 && left[(model_last + off) % NREQ] > 0)
                    j = (model_last + off) % NREQ;
            end
            if (j < 0) begin
                any = 0;
            end else begin
                ln = sat(dv[j]);
                sbq.push_back('{j, t + ln + 1});
                left[j]--;
                model_last = j;
                if (ln > mx) mx = ln;
                t = t + ln + 3;
            end
        end
        req    = mask;
        budget = t - cyc + 20;
        peak   = 0;
        while (req != '0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
            if (int'(cnt) > peak) peak = int'(cnt);
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    served[i]++;
                    if (served[i] >= need[i]) req[i] = 1'b0;
                end else if (gnt[i] && served[i] == need[i] - 1) begin
                    dly[i*CBITS +: CBITS] = CBITS'($urandom);
                end
            end
        end
        if (req != '0) begin
            check("round_timeout", req, 0);
            req = '0;
        end
        check("cnt_peak", peak, mx);
        @(posedge clk);
        #1;
        check("idle_after_round", busy, 0);
        check("queue_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic wait_cnt4(input string name);
        int b;
        b = 60;
        do begin
            @(posedge clk);
            #1;
            b--;
        end while (!(gnt[3] && cnt == 4) && b > 0);
        check(name, (gnt[3] && cnt == 4) ? 1 : 0, 1);
    endtask

    int dv[NREQ];
    logic [NREQ-1:0] m;
    logic [NREQ-1:0] h;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        run_round(4'b0001, '{5, 0, 0, 0}, 4'b0000);
        run_round(4'b1111, '{2, 2, 2, 2}, 4'b0001);
        run_round(4'b0100, '{0, 0, 2000, 0}, 4'b0000);
        run_round(4'b0010, '{0, 0, 0, 0}, 4'b0000);

        // abort by dropping req mid-count
        @(posedge clk);
        #1;
        dly[3*CBITS +: CBITS] = CBITS'(10);
        req = 4'b1000;
        model_last = 3;
        wait_cnt4("abort_reach_cnt4");
        req = '0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_gnt", gnt, 0);
        check("abort_cnt", cnt, 0);
        repeat (4) @(posedge clk);

        // reset mid-count
        #1;
        req = 4'b1000;
        wait_cnt4("rst_reach_cnt4");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_gnt", gnt, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt", cnt, 0);
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = NREQ - 1;
        run_round(4'b1001, '{3, 0, 0, 4}, 4'b0000);

        for (int r = 0; r < 30; r++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            h = NREQ'($urandom) & m;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 24) == 0) dv[i] = $urandom_range(MAXN + 1, 2047);
                else dv[i] = $urandom_range(0, 25);
            end
            run_round(m, dv, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
